// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared datatypes for the memory controller slice: FSM state
//               encoding, default transaction timeout and timeout counter
//               width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_REQ      = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_RESP     = 3'd4
    } mem_ctrl_state_t;

    // Default bus-cycle budget for one transaction.
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

    // Wide enough for the largest supported budget (65535).
    localparam int unsigned c_TMO_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/mem_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_cnt
// Description : Bus-phase cycle counter. Cleared while the controller is
//               capturing a request, counts every enabled cycle, and flags
//               expiry once LIMIT bus cycles have been spent.
// Ports       : clk, rst_n      - clock, async active-low reset
//               clear           - synchronous clear (priority over enable)
//               enable          - count this cycle
//               expired         - enabled cycle at/after the last allowed one
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [c_TMO_CNT_W-1:0] c_LAST = c_TMO_CNT_W'(LIMIT - 1);

    logic [c_TMO_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The count equals the index of the current bus cycle. A '>=' compare is
    // used because a handshake in the last allowed REQ cycle lets the count
    // step one past c_LAST in the first WAIT_RSP cycle.
    assign expired = enable && (r_cnt >= c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Bridges one-cycle read/write pulses from the control FSM onto
//               a word-wide valid/ready request channel with a separate,
//               non-backpressured response channel. Misaligned or conflicting
//               requests and stalled transactions complete with mem_err.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               mem_read, mem_write         - request pulses
//               mar, mdr                    - address / write data (cycle
//                                             after the pulse)
//               mem_resp, mem_rdata,
//               mem_err, mem_busy           - completion side
//               bus_req_*                   - request channel to memory
//               bus_rsp_*                   - response channel from memory
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mar,
    input  logic [31:0] mdr,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        mem_busy,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err
);

    mem_ctrl_state_t r_state;
    logic            r_resp;
    logic            r_err;
    logic            r_busy;
    logic            r_req_valid;
    logic            r_we;
    logic [31:0]     r_rdata;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;

    logic            w_tmo_clear;
    logic            w_tmo_enable;
    logic            w_tmo_expired;

    // CAPTURE always precedes REQ, so clearing there restarts the count on
    // every entry to REQ.
    assign w_tmo_clear  = (r_state == ST_CAPTURE);
    assign w_tmo_enable = (r_state == ST_REQ) || (r_state == ST_WAIT_RSP);

    mem_timeout_cnt #(
        .LIMIT   (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_tmo_clear),
        .enable  (w_tmo_enable),
        .expired (w_tmo_expired)
    );

    // Bus progress (handshake or response) takes priority over the timeout;
    // the abort only fires in a cycle where the bus made no progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_resp      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_req_valid <= 1'b0;
            r_we        <= 1'b0;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mem_read ^ mem_write) begin
                        r_state <= ST_CAPTURE;
                        r_we    <= mem_write;
                        r_busy  <= 1'b1;
                    end else if (mem_read && mem_write) begin
                        r_state <= ST_RESP;
                        r_resp  <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_addr  <= mar;
                    r_wdata <= mdr;
                    if (mar[1:0] != 2'b00) begin
                        r_state <= ST_RESP;
                        r_resp  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        r_state     <= ST_WAIT_RSP;
                        r_req_valid <= 1'b0;
                    end else if (w_tmo_expired) begin
                        r_state     <= ST_RESP;
                        r_req_valid <= 1'b0;
                        r_resp      <= 1'b1;
                        r_err       <= 1'b1;
                    end
                end
                ST_WAIT_RSP: begin
                    if (bus_rsp_valid) begin
                        r_state <= ST_RESP;
                        r_resp  <= 1'b1;
                        r_err   <= bus_rsp_err;
                        if (!r_we) begin
                            r_rdata <= bus_rsp_rdata;
                        end
                    end else if (w_tmo_expired) begin
                        r_state <= ST_RESP;
                        r_resp  <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_resp      = r_resp;
    assign mem_rdata     = r_rdata;
    assign mem_err       = r_err;
    assign mem_busy      = r_busy;
    assign bus_req_valid = r_req_valid;
    assign bus_req_we    = r_we;
    assign bus_req_addr  = r_addr;
    assign bus_req_wdata = r_wdata;

endmodule
`default_nettype wire
